// File: rtl/sc_random_pkg.sv
// Shared definitions for the random-number scheduler: state encoding,
// LFSR width/default seed, the LFSR step and the round-robin pick.
package sc_random_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1001;
    // Arbitration helpers work on a fixed 8-bit request vector (max NREQ).
    localparam int RR_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // One LFSR advance: shift left, feed back the parity of the old value.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^v};
    endfunction

    // First set request searching upward from ptr, wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        nreq);
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(nreq)) begin
                idx = idx - int'(nreq);
            end
            if ((k < int'(nreq)) && !r.found && req[idx[2:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_random_lfsr.sv
// 4-bit Fibonacci-style LFSR with step enable and seed load.
// A zero seed would lock the register up, so it is replaced by RESET_VAL.
module sc_random_lfsr
    import sc_random_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    // Load has priority over step; the all-zero seed is guarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= RESET_VAL;
        end else if (i_load) begin
            r_lfsr <= (i_load_val == '0) ? RESET_VAL : i_load_val;
        end else if (i_step) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/sc_random_scheduler.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters.
// Each grant costs one LFSR step (STEP), then the fresh value is delivered
// together with a one-cycle one-hot grant (DELIVER).
module sc_random_scheduler
    import sc_random_pkg::*;
#(
    parameter int                NREQ     = 4,
    parameter logic [LFSR_W-1:0] RND_SEED = DEFAULT_SEED
) (
    input  logic                SC_RandomSCHEDULER_CLOCK_50,
    input  logic                SC_RandomSCHEDULER_RESET_InLow,
    input  logic [NREQ-1:0]     SC_RandomSCHEDULER_req_InBUS,
    input  logic                SC_RandomSCHEDULER_tick_In,
    input  logic                SC_RandomSCHEDULER_seedLoad_In,
    input  logic [LFSR_W-1:0]   SC_RandomSCHEDULER_seed_InBUS,
    output logic [NREQ-1:0]     SC_RandomSCHEDULER_grant_OutBUS,
    output logic [LFSR_W-1:0]   SC_RandomSCHEDULER_data_OutBUS,
    output logic                SC_RandomSCHEDULER_busy_Out
);

    state_t            r_state;
    logic [2:0]        r_rr_ptr;
    logic [2:0]        r_winner;
    logic [NREQ-1:0]   r_grant;
    logic [LFSR_W-1:0] r_data;
    logic              r_busy;

    logic [LFSR_W-1:0] w_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic              w_lfsr_step;
    logic              w_lfsr_load;
    logic              w_any_req;
    logic [NREQ-1:0]   w_win_onehot;
    logic [RR_MAX-1:0] w_req_ext;
    logic [RR_MAX-1:0] w_req_masked;
    logic [2:0]        w_ptr_next;
    rr_pick_t          w_pick_idle;
    rr_pick_t          w_pick_dlv;

    assign w_any_req    = |SC_RandomSCHEDULER_req_InBUS;
    assign w_req_ext    = RR_MAX'(SC_RandomSCHEDULER_req_InBUS);
    assign w_lfsr_next  = lfsr_step(w_lfsr);
    assign w_ptr_next   = (r_winner == 3'(NREQ - 1)) ? 3'd0 : r_winner + 3'd1;

    // One-hot decode of the latched winner.
    always_comb begin
        w_win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_onehot[i] = (r_winner == 3'(i));
        end
    end

    // The current winner is excluded so it must re-request to be served again.
    assign w_req_masked = w_req_ext & ~RR_MAX'(w_win_onehot);
    assign w_pick_idle  = rr_pick(w_req_ext, r_rr_ptr, 4'(NREQ));
    assign w_pick_dlv   = rr_pick(w_req_masked, w_ptr_next, 4'(NREQ));

    // LFSR control: seed load and stir only while idle; one step per grant.
    assign w_lfsr_load = (r_state == ST_IDLE) && SC_RandomSCHEDULER_seedLoad_In;
    assign w_lfsr_step = (r_state == ST_STEP) ||
                         ((r_state == ST_IDLE) && !SC_RandomSCHEDULER_seedLoad_In &&
                          !w_any_req && SC_RandomSCHEDULER_tick_In);

    sc_random_lfsr #(
        .RESET_VAL (RND_SEED)
    ) u_lfsr (
        .i_clk      (SC_RandomSCHEDULER_CLOCK_50),
        .i_rst_n    (SC_RandomSCHEDULER_RESET_InLow),
        .i_step     (w_lfsr_step),
        .i_load     (w_lfsr_load),
        .i_load_val (SC_RandomSCHEDULER_seed_InBUS),
        .o_lfsr     (w_lfsr)
    );

    // Scheduler FSM with registered grant/data/busy outputs.
    always_ff @(posedge SC_RandomSCHEDULER_CLOCK_50 or negedge SC_RandomSCHEDULER_RESET_InLow) begin
        if (!SC_RandomSCHEDULER_RESET_InLow) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= 3'd0;
            r_winner <= 3'd0;
            r_grant  <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_grant <= '0;
                    if (!SC_RandomSCHEDULER_seedLoad_In && w_pick_idle.found) begin
                        r_winner <= w_pick_idle.idx;
                        r_state  <= ST_STEP;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // data must show the value this step produces, hence next.
                    r_data  <= w_lfsr_next;
                    r_grant <= w_win_onehot;
                    r_state <= ST_DELIVER;
                    r_busy  <= 1'b1;
                end
                ST_DELIVER: begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_ptr_next;
                    if (w_pick_dlv.found && !SC_RandomSCHEDULER_seedLoad_In) begin
                        r_winner <= w_pick_dlv.idx;
                        r_state  <= ST_STEP;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SC_RandomSCHEDULER_grant_OutBUS = r_grant;
    assign SC_RandomSCHEDULER_data_OutBUS  = r_data;
    assign SC_RandomSCHEDULER_busy_Out     = r_busy;

endmodule

// File: tb/tb_sc_random_scheduler.sv
// Testbench for sc_random_scheduler: directed vector table, hand-written
// asynchronous-reset sequence, and randomized run against a reference model.
module tb_sc_random_scheduler;

    localparam int NREQ = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       tick;
    logic       sl;
    logic [3:0] seed;
    logic [3:0] grant;
    logic [3:0] data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sc_random_scheduler #(
        .NREQ     (NREQ),
        .RND_SEED (4'b1001)
    ) dut (
        .SC_RandomSCHEDULER_CLOCK_50    (clk),
        .SC_RandomSCHEDULER_RESET_InLow (rst_n),
        .SC_RandomSCHEDULER_req_InBUS   (req),
        .SC_RandomSCHEDULER_tick_In     (tick),
        .SC_RandomSCHEDULER_seedLoad_In (sl),
        .SC_RandomSCHEDULER_seed_InBUS  (seed),
        .SC_RandomSCHEDULER_grant_OutBUS(grant),
        .SC_RandomSCHEDULER_data_OutBUS (data),
        .SC_RandomSCHEDULER_busy_Out    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       tick;
        logic       sl;
        logic [3:0] seed;
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic t,
                                input logic s, input logic [3:0] sd,
                                input logic [3:0] g, input logic [3:0] d, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.tick = t; v.sl = s; v.seed = sd;
        v.g = g; v.d = d; v.b = b;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset pulse at a negedge; outputs checked while reset is held.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; tick = 1'b0; sl = 1'b0; seed = '0;
        #1;
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_data",  32'(data),  32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply one vector for one clock, compare at the following negedge.
    task automatic run_vec(input vec_t v, input int idx);
        if (v.rst) do_reset();
        req = v.req; tick = v.tick; sl = v.sl; seed = v.seed;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_grant", idx), 32'(grant), 32'(v.g));
        check($sformatf("vec%0d_data",  idx), 32'(data),  32'(v.d));
        check($sformatf("vec%0d_busy",  idx), 32'(busy),  32'(v.b));
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 = waiting for work, 1 = draw pending, 2 = handing out draw.
    int m_lfsr, m_phase, m_win, m_ptr, m_grant, m_data, m_busy;

    function automatic int ref_step(input int v);
        int par;
        par = (v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3)) & 1;
        return ((v << 1) & 15) | par;
    endfunction

    function automatic int ref_pick(input int rq, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (((rq >> i) & 1) == 1) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_lfsr = 9; m_phase = 0; m_win = 0; m_ptr = 0;
        m_grant = 0; m_data = 0; m_busy = 0;
    endtask

    task automatic model_clock(input int rq, input int tk, input int s, input int sd);
        int cand, w;
        if (m_phase == 0) begin
            m_grant = 0;
            if (s != 0) begin
                m_lfsr = (sd == 0) ? 9 : sd;
            end else if (rq != 0) begin
                m_win = ref_pick(rq, m_ptr);
                m_phase = 1; m_busy = 1;
            end else if (tk != 0) begin
                m_lfsr = ref_step(m_lfsr);
            end
        end else if (m_phase == 1) begin
            m_lfsr = ref_step(m_lfsr);
            m_data = m_lfsr;
            m_grant = 1 << m_win;
            m_phase = 2;
        end else begin
            m_grant = 0;
            m_ptr = (m_win + 1) % NREQ;
            cand = rq & ~(1 << m_win);
            w = ref_pick(cand, m_ptr);
            if (w >= 0 && s == 0) begin
                m_win = w; m_phase = 1;
            end else begin
                m_phase = 0; m_busy = 0;
            end
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b1;
        req = '0; tick = 1'b0; sl = 1'b0; seed = '0;

        // Single request from reset
        add(1, 4'b0001, 0, 0, 4'h0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0001, 4'b0010, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b0010, 0);
        // Round-robin fairness from reset, grantee drops its bit
        add(1, 4'b1111, 0, 0, 4'h0, 4'b0000, 4'b0000, 1);
        add(0, 4'b1111, 0, 0, 4'h0, 4'b0001, 4'b0010, 1);
        add(0, 4'b1110, 0, 0, 4'h0, 4'b0000, 4'b0010, 1);
        add(0, 4'b1110, 0, 0, 4'h0, 4'b0010, 4'b0101, 1);
        add(0, 4'b1100, 0, 0, 4'h0, 4'b0000, 4'b0101, 1);
        add(0, 4'b1100, 0, 0, 4'h0, 4'b0100, 4'b1010, 1);
        add(0, 4'b1000, 0, 0, 4'h0, 4'b0000, 4'b1010, 1);
        add(0, 4'b1000, 0, 0, 4'h0, 4'b1000, 4'b0100, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b0100, 0);
        // Pointer wrap after requester 3: 0 first, then 3
        add(0, 4'b1001, 0, 0, 4'h0, 4'b0000, 4'b0100, 1);
        add(0, 4'b1001, 0, 0, 4'h0, 4'b0001, 4'b1001, 1);
        add(0, 4'b1000, 0, 0, 4'h0, 4'b0000, 4'b1001, 1);
        add(0, 4'b1000, 0, 0, 4'h0, 4'b1000, 4'b0010, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b0010, 0);
        // Seed priority with zero-seed guard, request held off
        add(0, 4'b0010, 0, 1, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 0, 1, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 0, 0, 4'h0, 4'b0000, 4'b0010, 1);
        add(0, 4'b0010, 0, 0, 4'h0, 4'b0010, 4'b0010, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b0010, 0);
        // Stir: reload 1001, three ticks, then request; ticks in STEP/DELIVER discarded
        add(0, 4'b0000, 0, 1, 4'h9, 4'b0000, 4'b0010, 0);
        add(0, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0010, 0);
        add(0, 4'b0001, 0, 0, 4'h0, 4'b0000, 4'b0010, 1);
        add(0, 4'b0001, 1, 0, 4'h0, 4'b0001, 4'b0100, 1);
        add(0, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0100, 0);
        add(0, 4'b0001, 0, 0, 4'h0, 4'b0000, 4'b0100, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0001, 4'b1001, 1);
        add(0, 4'b0000, 0, 0, 4'h0, 4'b0000, 4'b1001, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Asynchronous reset in the middle of DELIVER
        do_reset();
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        req = 4'b0000;
        @(posedge clk); @(negedge clk);
        check("pre_rst_grant", 32'(grant), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_busy",  32'(busy),  32'h0);
        check("async_rst_data",  32'(data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v.rst = 0; v.req = 4'b0001; v.tick = 0; v.sl = 0; v.seed = 0;
        v.g = 4'b0000; v.d = 4'b0000; v.b = 1;
        run_vec(v, 100);
        v.req = 4'b0000; v.g = 4'b0001; v.d = 4'b0010; v.b = 1;
        run_vec(v, 101);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            req  = 4'($urandom_range(0, 15));
            tick = 1'($urandom % 2);
            sl   = (($urandom % 8) == 0);
            seed = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom % 16);
            @(posedge clk);
            model_clock(int'(req), int'(tick), int'(sl), int'(seed));
            @(negedge clk);
            check($sformatf("rnd%0d_grant", c), 32'(grant), 32'(m_grant));
            check($sformatf("rnd%0d_data",  c), 32'(data),  32'(m_data));
            check($sformatf("rnd%0d_busy",  c), 32'(busy),  32'(m_busy));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
